// File: rtl/lfsr_decrypt.sv
// LFSR stream decryptor: identifies the tap pattern from a run of encrypted spaces at DM[64..127],
// then writes the decoded text, with leading spaces removed, to DM[0..63] and pads the rest with spaces.
module lfsr_decrypt (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic       err,
  output logic [3:0] pt_no,
  output logic [6:0] msg_len,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    SCAN   = 3'd2,
    PICK   = 3'd3,
    DECODE = 3'd4,
    PAD    = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam logic [8:0] MASK_ALL    = 9'h1FF;
  localparam logic [7:0] CT_BASE     = 8'd64;
  localparam logic [6:0] LAST_SCAN   = 7'd9;
  localparam logic [6:0] LAST_BYTE   = 7'd63;
  localparam logic [6:0] MSG_CAP     = 7'd64;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic logic [6:0] tap_of(input logic [3:0] p);
    logic [6:0] t;
    case (p)
      4'd0:    t = 7'h60;
      4'd1:    t = 7'h48;
      4'd2:    t = 7'h78;
      4'd3:    t = 7'h72;
      4'd4:    t = 7'h6A;
      4'd5:    t = 7'h69;
      4'd6:    t = 7'h5C;
      4'd7:    t = 7'h7E;
      4'd8:    t = 7'h7B;
      default: t = 7'h60;
    endcase
    return t;
  endfunction

  // Feedback bit is the parity of the tapped state bits.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  function automatic logic [3:0] lowest_set(input logic [8:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 8; k >= 0; k--) begin
      r = m[k] ? 4'(k) : r;
    end
    return r;
  endfunction

  state_e     state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [6:0] seed_q, seed_d;
  logic [6:0] prev_q, prev_d;
  logic [8:0] mask_q, mask_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] wptr_q, wptr_d;
  logic       started_q, started_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic [3:0] pt_no_q, pt_no_d;
  logic [6:0] msg_len_q, msg_len_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [6:0] cipher;
  logic [6:0] plain;
  logic       ct_parity_unused;

  assign cipher           = rd_data[6:0];
  assign ct_parity_unused = rd_data[7];

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seed_d    = seed_q;
    prev_d    = prev_q;
    mask_d    = mask_q;
    lfsr_d    = lfsr_q;
    wptr_d    = wptr_q;
    started_d = started_q;
    err_d     = err_q;
    pt_no_d   = pt_no_q;
    msg_len_d = msg_len_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    plain     = cipher ^ lfsr_q;

    case (state_q)
      IDLE: begin
        if (!req) begin
          state_d   = SEED;
          idx_d     = 7'd0;
          rd_addr_d = CT_BASE;
          mask_d    = MASK_ALL;
          lfsr_d    = 7'd0;
          wptr_d    = 7'd0;
          started_d = 1'b0;
          err_d     = 1'b0;
          pt_no_d   = 4'd0;
          msg_len_d = 7'd0;
        end else begin
          state_d = IDLE;
        end
      end

      SEED: begin
        seed_d = cipher;
        prev_d = cipher;
        if (cipher == 7'd0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          mask_d    = MASK_ALL;
          idx_d     = 7'd1;
          rd_addr_d = CT_BASE + 8'd1;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        // A pattern survives only if it predicts every consecutive ciphertext byte.
        for (int p = 0; p < 9; p++) begin
          mask_d[p] = mask_q[p] & (lfsr_step(prev_q, tap_of(4'(p))) == cipher);
        end
        prev_d = cipher;
        if (idx_q == LAST_SCAN) begin
          state_d = PICK;
        end else begin
          idx_d     = idx_q + 7'd1;
          rd_addr_d = CT_BASE + {1'b0, idx_d};
        end
      end

      PICK: begin
        pt_no_d = lowest_set(mask_q);
        if (mask_q == 9'd0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          lfsr_d    = seed_q;
          idx_d     = 7'd0;
          rd_addr_d = CT_BASE;
          state_d   = DECODE;
        end
      end

      DECODE: begin
        if (started_q || (plain != 7'd0)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {1'b0, wptr_q};
          wr_data_d = {1'b0, plain} + ASCII_SPACE;
          wptr_d    = wptr_q + 7'd1;
          msg_len_d = msg_len_q + 7'd1;
          started_d = 1'b1;
        end else begin
          wr_en_d = 1'b0;
        end
        lfsr_d = lfsr_step(lfsr_q, tap_of(pt_no_q));
        if (idx_q == LAST_BYTE) begin
          state_d = (wptr_d == MSG_CAP) ? DONE : PAD;
        end else begin
          idx_d     = idx_q + 7'd1;
          rd_addr_d = CT_BASE + {1'b0, idx_d};
        end
      end

      PAD: begin
        if (wptr_q < MSG_CAP) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {1'b0, wptr_q};
          wr_data_d = ASCII_SPACE;
          wptr_d    = wptr_q + 7'd1;
        end else begin
          wr_en_d = 1'b0;
        end
        if (wptr_d == MSG_CAP) begin
          state_d = DONE;
        end else begin
          state_d = PAD;
        end
      end

      DONE: begin
        // ack must have been visible at least once before the block may leave DONE.
        if (req && ack_q) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // ack rises one cycle after DONE is entered so the final write lands first.
    ack_d = (state_q == DONE) && (state_d == DONE);
  end

  // State and output registers with synchronous init.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q   <= IDLE;
      idx_q     <= 7'd0;
      seed_q    <= 7'd0;
      prev_q    <= 7'd0;
      mask_q    <= MASK_ALL;
      lfsr_q    <= 7'd0;
      wptr_q    <= 7'd0;
      started_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      pt_no_q   <= 4'd0;
      msg_len_q <= 7'd0;
      rd_addr_q <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seed_q    <= seed_d;
      prev_q    <= prev_d;
      mask_q    <= mask_d;
      lfsr_q    <= lfsr_d;
      wptr_q    <= wptr_d;
      started_q <= started_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      pt_no_q   <= pt_no_d;
      msg_len_q <= msg_len_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign pt_no   = pt_no_q;
  assign msg_len = msg_len_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
